// File: rtl/ship_placement_ctrl_pkg.sv
// Shared types, board geometry and cell addressing for the ship placement controller.
package ship_pkg;

  localparam int ROWS      = 5;
  localparam int COLS      = 5;
  localparam int MAX_SHIPS = 5;
  localparam int BOARD_W   = ROWS * COLS;
  localparam int IDX_W     = $clog2(BOARD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_POS,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_e;

  // Linear board bit (row*COLS+col) of cell c of a ship anchored at (row, col).
  function automatic logic [IDX_W-1:0] cell_index(input logic [2:0] row,
                                                  input logic [2:0] col,
                                                  input logic       vertical,
                                                  input logic [2:0] c);
    logic [6:0] r;
    logic [6:0] k;
    r = {4'd0, row} + (vertical ? {4'd0, c} : 7'd0);
    k = {4'd0, col} + (vertical ? 7'd0 : {4'd0, c});
    return IDX_W'(r * 7'(COLS) + k);
  endfunction

endpackage

// File: rtl/ship_placement_ctrl_if.sv
// Control/status bundle between the placement controller and its user.
interface ship_placement_ctrl_if;

  logic                        start;
  logic [2:0]                  num_ships;
  logic [2:0]                  cur_row;
  logic [2:0]                  cur_col;
  logic                        vertical;
  logic                        confirm;
  logic [ship_pkg::BOARD_W-1:0] board;
  logic [2:0]                  ship_idx;
  logic                        busy;
  logic                        place_err;
  logic                        done;

  modport master (
    output start, num_ships, cur_row, cur_col, vertical, confirm,
    input  board, ship_idx, busy, place_err, done
  );

  modport slave (
    input  start, num_ships, cur_row, cur_col, vertical, confirm,
    output board, ship_idx, busy, place_err, done
  );

endinterface

// File: rtl/ship_placement_ctrl_cell_walker.sv
// Steps through the cells of the current ship; shared by the overlap check and the board write.
module ship_cell_walker
  import ship_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic [2:0]       row_i,
  input  logic [2:0]       col_i,
  input  logic             vertical_i,
  input  logic [2:0]       len_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [2:0] c_q;
  logic [2:0] c_d;

  // Counter falls back to 0 whenever it is not advancing, so every walk starts at cell 0.
  assign c_d = step_i ? c_q + 3'd1 : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign idx_o  = cell_index(row_i, col_i, vertical_i, c_q);
  assign last_o = (c_q == len_i - 3'd1);

endmodule

// File: rtl/ship_placement_ctrl.sv
// Placement sequencer: ship k (length k) is bounds/overlap checked cell by cell, then written.
module ship_placement_ctrl
  import ship_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ship_placement_ctrl_if.slave bus
);

  state_e             state_q;
  logic [BOARD_W-1:0] board_q;
  logic [2:0]         ship_idx_q;
  logic [2:0]         n_q;
  logic [2:0]         row_q;
  logic [2:0]         col_q;
  logic               vert_q;
  logic               busy_q;
  logic               err_q;
  logic               done_q;

  logic [IDX_W-1:0]   cell_idx;
  logic               last_cell;
  logic               step;
  logic               start_ok;
  logic               in_bounds;
  logic               check_fail;
  logic [3:0]         row_end;
  logic [3:0]         col_end;

  assign start_ok = (bus.num_ships != 3'd0) && (bus.num_ships <= 3'(MAX_SHIPS));

  assign row_end   = {1'b0, row_q} + {1'b0, ship_idx_q};
  assign col_end   = {1'b0, col_q} + {1'b0, ship_idx_q};
  assign in_bounds = ({1'b0, row_q} < 4'(ROWS)) && ({1'b0, col_q} < 4'(COLS)) &&
                     (vert_q ? (row_end <= 4'(ROWS)) : (col_end <= 4'(COLS)));

  // Bounds are re-evaluated every CHECK cycle; they only ever fail on the first one.
  assign check_fail = !in_bounds || board_q[cell_idx];

  assign step = ((state_q == S_CHECK) && !check_fail && !last_cell) ||
                ((state_q == S_WRITE) && !last_cell);

  ship_cell_walker u_walker (
    .clk        (clk),
    .rst        (rst),
    .step_i     (step),
    .row_i      (row_q),
    .col_i      (col_q),
    .vertical_i (vert_q),
    .len_i      (ship_idx_q),
    .idx_o      (cell_idx),
    .last_o     (last_cell)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      board_q    <= '0;
      ship_idx_q <= '0;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      vert_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (start_ok) begin
              n_q        <= bus.num_ships;
              board_q    <= '0;
              ship_idx_q <= 3'd1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              state_q    <= S_WAIT_POS;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WAIT_POS: begin
          if (bus.confirm) begin
            row_q   <= bus.cur_row;
            col_q   <= bus.cur_col;
            vert_q  <= bus.vertical;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (check_fail) begin
            err_q   <= 1'b1;
            state_q <= S_WAIT_POS;
          end else if (last_cell) begin
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          board_q[cell_idx] <= 1'b1;
          if (last_cell) begin
            if (ship_idx_q == n_q) begin
              ship_idx_q <= 3'd0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              ship_idx_q <= ship_idx_q + 3'd1;
              state_q    <= S_WAIT_POS;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.board     = board_q;
  assign bus.ship_idx  = ship_idx_q;
  assign bus.busy      = busy_q;
  assign bus.place_err = err_q;
  assign bus.done      = done_q;

endmodule
